// File: rtl/pmic_pkg.sv
// pmic_pkg: shared channel constants and timer FSM encoding for the PMIC sequencer
package pmic_pkg;
  localparam int N_CH = 5;
  localparam logic [N_CH-1:0] T_NULL = 5'b00000;
  localparam logic [N_CH-1:0] T1 = 5'b00001;
  localparam logic [N_CH-1:0] T2 = 5'b00010;
  localparam logic [N_CH-1:0] T3 = 5'b00100;
  localparam logic [N_CH-1:0] T4 = 5'b01000;
  localparam logic [N_CH-1:0] T5 = 5'b10000;
  typedef enum logic [1:0] {IDLE, COUNT, DONE} tmr_state_t;
endpackage

// File: rtl/pmic_seq_timer_if.sv
// pmic_seq_timer_if: request, config and status signals between sequencer and timer
interface pmic_seq_timer_if #(
  parameter int N_CH = pmic_pkg::N_CH,
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
);
  logic [N_CH-1:0] sel;
  logic ld;
  logic abort;
  logic cfg_we;
  logic [2:0] cfg_addr;
  logic [CNT_W-1:0] cfg_data;
  logic [PRE_W-1:0] prescale;
  logic [N_CH-1:0] T;
  logic busy;
  logic [2:0] active_ch;
  logic err;
  modport master (output sel, ld, abort, cfg_we, cfg_addr, cfg_data, prescale, input T, busy, active_ch, err);
  modport slave (input sel, ld, abort, cfg_we, cfg_addr, cfg_data, prescale, output T, busy, active_ch, err);
endinterface

// File: rtl/pmic_prescaler.sv
// pmic_prescaler: emits one tick every prescale+1 enabled clocks, with synchronous clear
module pmic_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  input  logic [PRE_W-1:0] prescale,
  output logic tick
);
  logic [PRE_W-1:0] cnt;
  assign tick = en && cnt == prescale;
  // count enabled clocks, wrapping on each tick
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= clr ? '0 : en ? (tick ? '0 : cnt + 1'b1) : cnt;
endmodule

// File: rtl/pmic_seq_timer.sv
// pmic_seq_timer: queues one-hot delay requests and times them on one shared prescaled counter
module pmic_seq_timer #(
  parameter int N_CH = pmic_pkg::N_CH,
  parameter int CNT_W = 16,
  parameter int PRE_W = 8,
  parameter logic [CNT_W-1:0] DEF_DLY = 16'd100
) (
  input logic clk,
  input logic reset_n,
  pmic_seq_timer_if.slave bus
);
  pmic_pkg::tmr_state_t state, nxt;
  logic [N_CH-1:0] pend, gnt;
  logic [CNT_W-1:0] dly [N_CH];
  logic [CNT_W-1:0] cnt;
  logic [2:0] idx, act;
  logic tick, onehot, grant, err_q;
  assign onehot = bus.sel != '0 && (bus.sel & (bus.sel - 1'b1)) == '0;
  assign grant = state == pmic_pkg::IDLE && pend != '0 && !bus.abort;
  assign bus.busy = state != pmic_pkg::IDLE;
  assign bus.active_ch = bus.busy ? act : 3'd0;
  assign bus.T = state == pmic_pkg::DONE ? N_CH'(1) << act : '0;
  assign bus.err = err_q;
  pmic_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk(clk), .reset_n(reset_n), .clr(grant), .en(state == pmic_pkg::COUNT),
    .prescale(bus.prescale), .tick(tick)
  );
  // lowest pending index wins the grant
  always_comb begin
    idx = 3'd0;
    for (int i = N_CH - 1; i >= 0; i--) if (pend[i]) idx = 3'(i);
    gnt = '0;
    gnt[idx] = grant;
  end
  // next state: abort dominates, zero count ends the run
  always_comb begin
    nxt = bus.abort ? pmic_pkg::IDLE
        : state == pmic_pkg::IDLE ? (pend != '0 ? pmic_pkg::COUNT : pmic_pkg::IDLE)
        : state == pmic_pkg::COUNT ? (cnt == '0 ? pmic_pkg::DONE : pmic_pkg::COUNT)
        : pmic_pkg::IDLE;
  end
  // state, pending queue, counter and delay register file
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= pmic_pkg::IDLE;
      pend <= '0;
      cnt <= '0;
      act <= 3'd0;
      err_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) dly[i] <= DEF_DLY;
    end else begin
      state <= nxt;
      err_q <= bus.ld && !onehot && !bus.abort;
      pend <= bus.abort ? '0 : (pend & ~gnt) | (bus.ld && onehot ? bus.sel : '0);
      if (grant) begin
        cnt <= dly[idx];
        act <= idx;
      end else if (state == pmic_pkg::COUNT && tick && cnt != '0) cnt <= cnt - 1'b1;
      if (bus.cfg_we && 32'(bus.cfg_addr) < N_CH) dly[bus.cfg_addr] <= bus.cfg_data;
    end
endmodule

// File: tb/tb_pmic_seq_timer.sv
// tb_pmic_seq_timer: directed scoreboard bench for the shared delay timer
module tb_pmic_seq_timer;
  import pmic_pkg::*;
  typedef struct {logic [4:0] t; int cyc;} exp_t;
  logic clk = 0, reset_n = 0;
  int cyc = 0, checks = 0, failures = 0, c;
  exp_t tq[$];
  int eq[$];
  pmic_seq_timer_if bus();
  pmic_seq_timer dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic at_cyc(int k);
    repeat (k - cyc) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic req(logic [4:0] s);
    bus.sel = s;
    bus.ld = 1;
    step();
    bus.ld = 0;
    bus.sel = '0;
  endtask
  task automatic cfg(int a, int d);
    bus.cfg_we = 1;
    bus.cfg_addr = 3'(a);
    bus.cfg_data = 16'(d);
    step();
    bus.cfg_we = 0;
  endtask
  always @(negedge clk) if (reset_n) begin
    exp_t e;
    if (bus.T != '0) begin
      checks++;
      if (tq.size() == 0) begin
        failures++;
        $display("FAIL t_unexpected actual=%b@%0d required=none", bus.T, cyc);
      end else begin
        e = tq.pop_front();
        if (bus.T !== e.t || cyc != e.cyc) begin
          failures++;
          $display("FAIL t_pulse actual=%b@%0d required=%b@%0d", bus.T, cyc, e.t, e.cyc);
        end
      end
    end
    if (bus.err) begin
      checks++;
      if (eq.size() == 0) begin
        failures++;
        $display("FAIL err_unexpected actual=1@%0d required=none", cyc);
      end else if (eq[0] != cyc) begin
        failures++;
        $display("FAIL err_pulse actual=@%0d required=@%0d", cyc, eq.pop_front());
      end else void'(eq.pop_front());
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    bus.sel = '0; bus.ld = 0; bus.abort = 0; bus.cfg_we = 0;
    bus.cfg_addr = 0; bus.cfg_data = 0; bus.prescale = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_T", bus.T, 0);
    chk("rst_act", bus.active_ch, 0);
    chk("rst_err", bus.err, 0);
    step();
    reset_n = 1;
    cfg(0, 0);
    c = cyc; tq.push_back('{T1, c + 3}); req(T1);
    at_cyc(c + 1); chk("d0_busy1", bus.busy, 0);
    at_cyc(c + 2); chk("d0_busy2", bus.busy, 1);
    at_cyc(c + 3); chk("d0_busy3", bus.busy, 1);
    at_cyc(c + 4); chk("d0_busy4", bus.busy, 0);
    step();
    cfg(1, 4);
    bus.prescale = 2;
    c = cyc; tq.push_back('{T2, c + 15}); req(T2);
    at_cyc(c + 5); chk("p2_active", bus.active_ch, 1);
    at_cyc(c + 17);
    step();
    bus.prescale = 0;
    cfg(4, 2);
    cfg(2, 1);
    c = cyc; tq.push_back('{T5, c + 5}); tq.push_back('{T3, c + 9});
    req(T5); req(T3); req(T3);
    at_cyc(c + 7); chk("b2b_active", bus.active_ch, 2);
    at_cyc(c + 12);
    step();
    c = cyc; eq.push_back(c + 1); req(5'b00011);
    step();
    eq.push_back(c + 3); req(T_NULL);
    at_cyc(c + 6); chk("err_nopend", bus.busy, 0);
    step();
    cfg(0, 10); cfg(1, 10); cfg(3, 3);
    c = cyc; req(T1); req(T2); req(T4);
    step(); step();
    bus.abort = 1;
    step();
    bus.abort = 0;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_act", bus.active_ch, 0);
    at_cyc(c + 40); chk("abort_pend", bus.busy, 0);
    step();
    cfg(0, 50);
    c = cyc; req(T1);
    at_cyc(c + 10);
    chk("mid_busy", bus.busy, 1);
    #2 reset_n = 0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_T", bus.T, 0);
    chk("arst_act", bus.active_ch, 0);
    step();
    reset_n = 1;
    c = cyc; tq.push_back('{T1, c + 103}); req(T1);
    at_cyc(c + 105);
    chk("tq_empty", tq.size(), 0);
    chk("eq_empty", eq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
